// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver state encoding, oversampling constants and
// a parity helper. Imported by the receiver and reusable by the transmit side.
// Optional feature macro: UART_RX_PARITY_EN (selects the PARITY state usage).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int MID_SAMPLE = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Bundles the serial input and the byte-side outputs of the UART receiver.
//   rx_i          serial line into the receiver (idle high)
//   data_o        last correctly received byte
//   data_valid_o  one-cycle pulse, data_o is new
//   frame_err_o   one-cycle pulse, stop bit sampled low
//   parity_err_o  one-cycle pulse, parity mismatch
//   busy_o        receiver is inside a frame
// Modports: master = line driver / byte consumer, slave = the receiver.
// -----------------------------------------------------------------------------
interface uart_receiver_if;
    logic       rx_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       busy_o;

    modport master (
        output rx_i,
        input  data_o,
        input  data_valid_o,
        input  frame_err_o,
        input  parity_err_o,
        input  busy_o
    );

    modport slave (
        input  rx_i,
        output data_o,
        output data_valid_o,
        output frame_err_o,
        output parity_err_o,
        output busy_o
    );
endinterface

// File: rtl/uart_rx_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_rx_baud_tick
// Oversample tick generator: counts 0..BAUD_DIV-1 and flags the last count.
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   clear_i  synchronous counter clear (holds the count at 0)
//   tick_o   high for one cycle every BAUD_DIV cycles (count == BAUD_DIV-1)
// -----------------------------------------------------------------------------
module uart_rx_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] baud_cnt_q;
    logic [CW-1:0] baud_cnt_d;

    always_comb begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (clear_i || (baud_cnt_q == LAST)) begin
            baud_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

    assign tick_o = (baud_cnt_q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// UART receive stage: 8N1 frames (8E1 with UART_RX_PARITY_EN defined), 16x
// oversampling, mid-bit sampling. Each good byte is presented with a one-cycle
// data_valid_o pulse; framing / parity errors give one-cycle error pulses.
//   clk_i    clock, all logic on posedge
//   reset_i  synchronous active-high reset
//   rx_if    uart_receiver_if.slave (rx_i in; data/valid/errors/busy out)
// Parameter BAUD_DIV: clk_i cycles per oversample tick (>= 2).
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data bit 7).
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 27
) (
    input  logic           clk_i,
    input  logic           reset_i,
    uart_receiver_if.slave rx_if
);

    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    // Synchronizer, previous-value flop and registered falling edge.
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic fall_q;

    rx_state_e      state_q;
    logic [3:0]     sample_cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic [7:0]     data_q;
    logic           valid_q;
    logic           ferr_q;
    logic           busy_q;
    logic           tick;
    logic           baud_clear;

`ifdef UART_RX_PARITY_EN
    logic           perr_q;
    logic           parity_bad_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= rx_if.rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fall_q  <= prev_q & ~sync2_q;
        end
    end

    // Baud counter is held at zero while idle, so it starts from zero on
    // entry to START and the 8th tick lands at the middle of the start bit.
    assign baud_clear = (state_q == IDLE);

    uart_rx_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (baud_clear),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            // 4-bit sample counter wraps 15 -> 0 on its own inside a bit.
            if (tick) begin
                sample_cnt_q <= sample_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    sample_cnt_q <= '0;
                    if (fall_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (tick && (sample_cnt_q == MID_LAST)) begin
                        if (!sync2_q) begin
                            state_q      <= DATA;
                            sample_cnt_q <= '0;
                            bit_idx_q    <= '0;
                        end else begin
                            // Line went back high: glitch, not a start bit.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (tick && (sample_cnt_q == BIT_LAST)) begin
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick && (sample_cnt_q == BIT_LAST)) begin
                        parity_bad_q <= sync2_q ^ even_parity(shift_q);
                        state_q      <= STOP;
                    end
                end
`endif

                STOP: begin
                    // Leave at mid-stop so a following start edge is caught
                    // even with zero idle time between frames.
                    if (tick && (sample_cnt_q == BIT_LAST)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!sync2_q) begin
                            ferr_q <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        if (parity_bad_q) begin
                            perr_q <= 1'b1;
                        end
                        if (sync2_q && !parity_bad_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
`else
                        if (sync2_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
`endif
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.data_o       = data_q;
    assign rx_if.data_valid_o = valid_q;
    assign rx_if.frame_err_o  = ferr_q;
    assign rx_if.busy_o       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err_o = perr_q;
`else
    assign rx_if.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver with BAUD_DIV = 4 (64 clocks per bit).
// Define UART_RX_PARITY_EN for both bench and RTL to exercise parity frames.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int BAUD_DIV = 4;
    localparam int BIT_CYC  = 16 * BAUD_DIV;
    localparam int LAT      = 152 * BAUD_DIV + 3;
    localparam int LAT_PAR  = 168 * BAUD_DIV + 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_receiver_if u_if ();

    uart_receiver #(
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .rx_if   (u_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling edge.
    int         valid_cnt = 0;
    int         fe_cnt    = 0;
    int         pe_cnt    = 0;
    int         fe_cyc    = 0;
    int         pe_cyc    = 0;
    int         v_cyc  [16];
    logic [7:0] v_data [16];

    always @(negedge clk) begin
        if (!reset) begin
            if (u_if.data_valid_o) begin
                if (valid_cnt < 16) begin
                    v_cyc[valid_cnt]  = cyc;
                    v_data[valid_cnt] = u_if.data_o;
                end
                valid_cnt = valid_cnt + 1;
                $display("[%0d] rx byte 0x%02h", cyc, u_if.data_o);
            end
            if (u_if.frame_err_o) begin
                fe_cnt = fe_cnt + 1;
                fe_cyc = cyc;
                $display("[%0d] rx frame error pulse", cyc);
            end
            if (u_if.parity_err_o) begin
                pe_cnt = pe_cnt + 1;
                pe_cyc = cyc;
                $display("[%0d] rx parity error pulse", cyc);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves time 1ns after the n-th following posedge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic has_par, input logic par_b);
        $display("[%0d] tx byte 0x%02h stop=%0b par_en=%0b par=%0b", cyc, d, stop_b, has_par, par_b);
        u_if.rx_i = 1'b0;
        wait_cycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            u_if.rx_i = d[i];
            wait_cycles(BIT_CYC);
        end
        if (has_par) begin
            u_if.rx_i = par_b;
            wait_cycles(BIT_CYC);
        end
        u_if.rx_i = stop_b;
        wait_cycles(BIT_CYC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int v0, f0;

        u_if.rx_i = 1'b1;
        reset     = 1'b1;
        wait_cycles(3);
        check_eq("reset_data",  u_if.data_o, 8'h00);
        check_eq("reset_valid", u_if.data_valid_o, 1'b0);
        check_eq("reset_ferr",  u_if.frame_err_o, 1'b0);
        check_eq("reset_perr",  u_if.parity_err_o, 1'b0);
        check_eq("reset_busy",  u_if.busy_o, 1'b0);
        reset = 1'b0;
        wait_cycles(10);

        // Good frame 0xA5.
        v0 = valid_cnt; f0 = fe_cnt;
        start = cyc + 1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_cycles(20);
        check_eq("a5_valid_cnt", valid_cnt - v0, 1);
        check_eq("a5_latency",   v_cyc[v0] - start, LAT);
        check_eq("a5_data",      u_if.data_o, 8'hA5);
        check_eq("a5_ferr_cnt",  fe_cnt - f0, 0);
        check_eq("a5_busy_idle", u_if.busy_o, 1'b0);

        // 12-cycle low glitch: false start, no pulses.
        v0 = valid_cnt; f0 = fe_cnt;
        u_if.rx_i = 1'b0;
        wait_cycles(12);
        check_eq("glitch_busy_hi", u_if.busy_o, 1'b1);
        u_if.rx_i = 1'b1;
        wait_cycles(24);
        check_eq("glitch_busy_lo", u_if.busy_o, 1'b0);
        wait_cycles(100);
        check_eq("glitch_valid_cnt", valid_cnt - v0, 0);
        check_eq("glitch_ferr_cnt",  fe_cnt - f0, 0);
        check_eq("glitch_data",      u_if.data_o, 8'hA5);

        // 0x3C with stop low, line held low afterwards.
        v0 = valid_cnt; f0 = fe_cnt;
        start = cyc + 1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_cycles(200);
        check_eq("ferr_busy_low_line", u_if.busy_o, 1'b0);
        u_if.rx_i = 1'b1;
        wait_cycles(100);
        check_eq("ferr_cnt",       fe_cnt - f0, 1);
        check_eq("ferr_latency",   fe_cyc - start, LAT);
        check_eq("ferr_valid_cnt", valid_cnt - v0, 0);
        check_eq("ferr_data_hold", u_if.data_o, 8'hA5);
        check_eq("ferr_busy",      u_if.busy_o, 1'b0);

        // Back-to-back 0x00, 0xFF with no idle gap.
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        wait_cycles(50);
        check_eq("b2b_valid_cnt", valid_cnt - v0, 2);
        check_eq("b2b_spacing",   v_cyc[v0 + 1] - v_cyc[v0], 10 * BIT_CYC);
        check_eq("b2b_data0",     v_data[v0], 8'h00);
        check_eq("b2b_data1",     v_data[v0 + 1], 8'hFF);
        check_eq("b2b_data_o",    u_if.data_o, 8'hFF);

        // Reset during data bit 3 of 0x81.
        v0 = valid_cnt;
        u_if.rx_i = 1'b0; wait_cycles(BIT_CYC);   // start
        u_if.rx_i = 1'b1; wait_cycles(BIT_CYC);   // bit 0
        u_if.rx_i = 1'b0; wait_cycles(BIT_CYC);   // bit 1
        wait_cycles(BIT_CYC);                     // bit 2
        wait_cycles(BIT_CYC / 2);                 // half of bit 3
        check_eq("mid_busy_before", u_if.busy_o, 1'b1);
        reset = 1'b1;
        wait_cycles(1);
        check_eq("mid_reset_data", u_if.data_o, 8'h00);
        check_eq("mid_reset_busy", u_if.busy_o, 1'b0);
        reset     = 1'b0;
        u_if.rx_i = 1'b1;
        wait_cycles(50);
        check_eq("mid_after_busy",  u_if.busy_o, 1'b0);
        check_eq("mid_after_valid", valid_cnt - v0, 0);
        v0 = valid_cnt;
        start = cyc + 1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        wait_cycles(20);
        check_eq("5a_valid_cnt", valid_cnt - v0, 1);
        check_eq("5a_latency",   v_cyc[v0] - start, LAT);
        check_eq("5a_data",      u_if.data_o, 8'h5A);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1.
        v0 = valid_cnt; f0 = pe_cnt;
        start = cyc + 1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_cycles(20);
        check_eq("par_ok_valid_cnt", valid_cnt - v0, 1);
        check_eq("par_ok_latency",   v_cyc[v0] - start, LAT_PAR);
        check_eq("par_ok_data",      u_if.data_o, 8'h07);
        check_eq("par_ok_perr_cnt",  pe_cnt - f0, 0);

        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        wait_cycles(20);
        check_eq("par_5a_data", u_if.data_o, 8'h5A);

        v0 = valid_cnt; f0 = pe_cnt;
        start = cyc + 1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        wait_cycles(20);
        check_eq("par_bad_perr_cnt",  pe_cnt - f0, 1);
        check_eq("par_bad_latency",   pe_cyc - start, LAT_PAR);
        check_eq("par_bad_valid_cnt", valid_cnt - v0, 0);
        check_eq("par_bad_data_hold", u_if.data_o, 8'h5A);
`else
        check_eq("no_parity_pulses", pe_cnt, 0);
        check_eq("perr_tied_low",    u_if.parity_err_o, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
